// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the MCU fetch path.
// Arbitrates control-flow requests into the next-PC mux select, supplies the
// sequential/return/interrupt operands, registers the new PC, and owns the
// return-address stack (RAS) and the single-level interrupt-in-service state.
// Optional build macro RAS_WRAP_EN: when defined, a push onto a full RAS
// overwrites the oldest entry instead of being dropped.
module pc_sequencer #(
  parameter int                ADDR_W       = 10,
  parameter int                STACK_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] IRQ_VECTOR   = ADDR_W'(4)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic              call,
  input  logic              ret,
  input  logic              reti,
  input  logic              irq_req,
  input  logic [ADDR_W-1:0] next_pc,
  output logic [2:0]        sel,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic [ADDR_W-1:0] ret_addr,
  output logic [ADDR_W-1:0] irq_vec,
  output logic              irq_ack,
  output logic              in_isr,
  output logic              ras_ovf,
  output logic              ras_unf
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SP_W  = IDX_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              in_isr_q, in_isr_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic              irq_win;
  logic              push, pop;
  logic              ras_full, ras_empty;
  logic [IDX_W-1:0]  top_idx;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [ADDR_W-1:0] push_val;
`ifdef RAS_WRAP_EN
  logic              shift_en;
`endif

  assign pc        = pc_q;
  assign pc_plus1  = pc_q + ADDR_W'(1);
  assign irq_vec   = IRQ_VECTOR;
  assign irq_ack   = irq_win;
  assign in_isr    = in_isr_q;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;
  assign ras_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign ras_empty = (sp_q == '0);
  assign top_idx   = IDX_W'(sp_q - SP_W'(1));
  assign ret_addr  = ras_empty ? RESET_VECTOR : stack_q[top_idx];

  // Request arbitration, mux select and next-state for PC, RAS pointer and flags
  always_comb begin
    irq_win  = irq_req & ~in_isr_q & ~stall;
    sel      = 3'd0;
    pc_d     = pc_q;
    sp_d     = sp_q;
    in_isr_d = in_isr_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    wr_en    = 1'b0;
    wr_idx   = IDX_W'(sp_q);
`ifdef RAS_WRAP_EN
    shift_en = 1'b0;
`endif

    if (irq_win)                 sel = 3'd4;
    else if (ret | reti)         sel = 3'd3;
    else if (call | jump)        sel = 3'd2;
    else if (branch_taken)       sel = 3'd1;

    // An accepted interrupt saves the preempted PC so it re-executes after reti
    push_val = irq_win ? pc_q : pc_plus1;
    push     = ~stall & (irq_win | (call & ~ret & ~reti));
    pop      = ~stall & ~irq_win & (ret | reti);

    if (!stall) pc_d = next_pc;

    if (push) begin
      if (!ras_full) begin
        sp_d  = sp_q + SP_W'(1);
        wr_en = 1'b1;
      end else begin
        ovf_d = 1'b1;
`ifdef RAS_WRAP_EN
        shift_en = 1'b1;
`endif
      end
    end

    if (pop) begin
      if (!ras_empty) sp_d  = sp_q - SP_W'(1);
      else            unf_d = 1'b1;
    end

    if (irq_win)              in_isr_d = 1'b1;
    else if (pop && reti)     in_isr_d = 1'b0;
  end

  // Control state register; reset wins over stall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_VECTOR;
      sp_q     <= '0;
      in_isr_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      in_isr_q <= in_isr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // RAS storage; contents are invalidated by the pointer reset, not cleared
  always_ff @(posedge clk) begin
    if (wr_en) begin
      stack_q[wr_idx] <= push_val;
    end
`ifdef RAS_WRAP_EN
    else if (shift_en) begin
      for (int i = 0; i < STACK_DEPTH - 1; i++) begin
        stack_q[i] <= stack_q[i+1];
      end
      stack_q[STACK_DEPTH-1] <= push_val;
    end
`endif
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by random traffic,
// checked against a queue-based reference model through a scoreboard.
module tb_pc_sequencer;

  localparam logic [9:0] RV  = 10'h000;
  localparam logic [9:0] IV  = 10'h004;
  localparam int         DEP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, call = 1'b0;
  logic       ret = 1'b0, reti = 1'b0, irq_req = 1'b0;
  logic [9:0] next_pc = '0;
  logic [2:0] sel;
  logic [9:0] pc, pc_plus1, ret_addr, irq_vec;
  logic       irq_ack, in_isr, ras_ovf, ras_unf;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .jump(jump), .call(call), .ret(ret), .reti(reti), .irq_req(irq_req),
    .next_pc(next_pc), .sel(sel), .pc(pc), .pc_plus1(pc_plus1),
    .ret_addr(ret_addr), .irq_vec(irq_vec), .irq_ack(irq_ack),
    .in_isr(in_isr), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic       ack;
    logic [9:0] pc;
    logic [9:0] pc1;
    logic [9:0] ra;
    logic       isr;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  logic [9:0] m_pc;
  logic [9:0] m_ras[$];
  logic       m_isr, m_ovf, m_unf;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_push(input logic [9:0] v);
    if (m_ras.size() < DEP) m_ras.push_back(v);
    else begin
      m_ovf = 1'b1;
`ifdef RAS_WRAP_EN
      void'(m_ras.pop_front());
      m_ras.push_back(v);
`endif
    end
  endfunction

  // One clock of stimulus: the bench plays the next-PC mux and records expectations
  task automatic step(input bit r, input bit s, input bit b, input bit j,
                      input bit c, input bit rt, input bit rti, input bit iq,
                      input logic [9:0] tgt);
    logic       irq;
    logic [2:0] es;
    logic [9:0] top, nxt;
    exp_t       e;
    @(negedge clk);
    rst_n = r; stall = s; branch_taken = b; jump = j; call = c;
    ret = rt; reti = rti; irq_req = iq;
    if (!r) begin
      next_pc = tgt;
      m_pc = RV; m_ras.delete(); m_isr = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      return;
    end
    irq = iq && !m_isr && !s;
    es  = irq ? 3'd4 : (rt || rti) ? 3'd3 : (c || j) ? 3'd2 : b ? 3'd1 : 3'd0;
    top = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : RV;
    case (es)
      3'd0:    nxt = m_pc + 10'd1;
      3'd3:    nxt = top;
      3'd4:    nxt = IV;
      default: nxt = tgt;
    endcase
    next_pc = nxt;
    e.sel = es; e.ack = irq; e.pc = m_pc; e.pc1 = m_pc + 10'd1; e.ra = top;
    e.isr = m_isr; e.ovf = m_ovf; e.unf = m_unf;
    exp_q.push_back(e);
    if (!s) begin
      if (irq) begin
        model_push(m_pc);
        m_isr = 1'b1;
      end else if (es == 3'd3) begin
        if (m_ras.size() > 0) void'(m_ras.pop_back());
        else m_unf = 1'b1;
        if (rti) m_isr = 1'b0;
      end else if (c) begin
        model_push(m_pc + 10'd1);
      end
      m_pc = nxt;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 10'h000);
  endtask

  // Monitor: every cycle the DUT presents a result; compare against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sel",      {7'd0, sel},     {7'd0, e.sel});
        check("irq_ack",  {9'd0, irq_ack}, {9'd0, e.ack});
        check("pc",       pc,              e.pc);
        check("pc_plus1", pc_plus1,        e.pc1);
        check("ret_addr", ret_addr,        e.ra);
        check("irq_vec",  irq_vec,         IV);
        check("in_isr",   {9'd0, in_isr},  {9'd0, e.isr});
        check("ras_ovf",  {9'd0, ras_ovf}, {9'd0, e.ovf});
        check("ras_unf",  {9'd0, ras_unf}, {9'd0, e.unf});
      end
    end
  end

  initial begin
    m_pc = RV; m_isr = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    // Reset then sequential fetch
    step(0, 0, 0, 0, 0, 0, 0, 0, 10'h000);
    step(0, 0, 0, 0, 0, 0, 0, 0, 10'h000);
    idle(4);
    // Call from 010 to 100, return at 105
    step(1, 0, 1, 0, 0, 0, 0, 0, 10'h010);
    step(1, 0, 0, 0, 1, 0, 0, 0, 10'h100);
    idle(5);
    step(1, 0, 0, 0, 0, 1, 0, 0, 10'h000);
    idle(1);
    // Interrupt at 020, masked second request, reti back to 020
    step(1, 0, 1, 0, 0, 0, 0, 0, 10'h020);
    step(1, 0, 0, 0, 0, 0, 0, 1, 10'h000);
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0, 1, 10'h000);
    step(1, 0, 0, 0, 0, 0, 1, 0, 10'h000);
    idle(1);
    // Five nested calls overflow the stack, then four returns
    step(1, 0, 1, 0, 0, 0, 0, 0, 10'h030);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1, 0, 0, 0, 10'h031 + 10'(i));
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 1, 0, 0, 10'h000);
    // Return with empty stack underflows to the reset vector
    step(1, 0, 0, 0, 0, 1, 0, 0, 10'h000);
    idle(2);
    // Stall at 3FF with a branch pending, then wrap to 000
    step(1, 0, 1, 0, 0, 0, 0, 0, 10'h3FF);
    step(1, 1, 1, 0, 0, 0, 0, 0, 10'h155);
    step(1, 1, 1, 0, 0, 0, 0, 1, 10'h155);
    idle(2);
    // Reset in the middle of a call sequence
    step(1, 0, 0, 0, 1, 0, 0, 0, 10'h200);
    step(1, 0, 0, 0, 1, 0, 0, 0, 10'h240);
    step(0, 0, 0, 0, 1, 0, 0, 0, 10'h000);
    idle(3);
    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, s, iq, rt, rti, c, j, b;
      r   = ($urandom_range(0, 199) != 0);
      s   = ($urandom_range(0, 5) == 0);
      iq  = ($urandom_range(0, 9) == 0);
      rt  = ($urandom_range(0, 6) == 0);
      rti = ($urandom_range(0, 7) == 0);
      c   = ($urandom_range(0, 4) == 0);
      j   = ($urandom_range(0, 9) == 0);
      b   = ($urandom_range(0, 4) == 0);
      step(r, s, b, j, c, rt, rti, iq, 10'($urandom_range(0, 1023)));
    end
    idle(2);
    @(negedge clk);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got=%0d pending expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter sequencer for the MCU fetch path, directly upstream of the 5-channel 10-bit next-PC multiplexer.
- Every cycle it decodes control-flow requests into the 3-bit mux select and supplies the sequential address, return address and interrupt vector operands.
- It registers the selected mux output as the new PC.
- It owns a small hardware return-address stack (RAS) and the single-level interrupt-in-service state.

Parameters:
ADDR_W, 10, PC / instruction address width (matches mux word size)
STACK_DEPTH, 4, RAS entries (power of two)
RESET_VECTOR, 10'h000, PC value after reset
IRQ_VECTOR, 10'h004, interrupt handler entry address

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset
stall  input  1  hold PC, RAS and ISR state this cycle
branch_taken  input  1  conditional branch resolved taken
jump  input  1  unconditional jump
call  input  1  subroutine call (jump + push)
ret  input  1  subroutine return (pop)
reti  input  1  return from interrupt (pop + leave ISR)
irq_req  input  1  level interrupt request
next_pc  input  ADDR_W  mux_out of the next-PC mux
sel  output  3  mux select: 0 seq, 1 branch, 2 jump/call, 3 return, 4 IRQ
pc  output  ADDR_W  current PC, registered
pc_plus1  output  ADDR_W  pc+1, drives mux data_a
ret_addr  output  ADDR_W  RAS top, drives mux data_d
irq_vec  output  ADDR_W  constant IRQ_VECTOR, drives mux data_e
irq_ack  output  1  interrupt accepted this cycle
in_isr  output  1  handler executing
ras_ovf  output  1  sticky: push attempted when full
ras_unf  output  1  sticky: pop attempted when empty

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous, active-low.
- Reset values: pc=RESET_VECTOR, RAS empty (sp=0), in_isr=0, ras_ovf=0, ras_unf=0.
- Reset has priority over stall and is honoured mid-operation; RAS contents are discarded.
- sel and irq_ack are combinational from the current inputs and state.
- Priority, highest first, with sel value:
  - irq (irq_req & ~in_isr & ~stall) -> 4
  - ret|reti -> 3
  - call|jump -> 2
  - branch_taken -> 1
  - else -> 0
- Requests that lose arbitration are discarded; the instruction is refetched or re-executed.
- irq_ack = 1 exactly when the IRQ path wins.
- PC update: if ~stall, pc <= next_pc at the rising edge. Latency is one cycle from request to new pc.
- pc_plus1 = pc+1 mod 2^ADDR_W; 10'h3FF wraps to 10'h000.
- Stall: sel is still driven. pc, RAS, in_isr and flags do not change. irq_ack = 0.
- RAS push:
  - call pushes pc_plus1.
  - IRQ accept pushes pc; the preempted instruction is re-executed after reti.
  - sp increments.
- RAS pop: ret or reti pops; sp decrements. ret_addr always shows the top entry.
- Empty RAS:
  - ret_addr = RESET_VECTOR.
  - A pop leaves sp=0 and sets ras_unf.
  - sel is still 3, so the PC goes to RESET_VECTOR.
- Full RAS (sp==STACK_DEPTH): a push is dropped, sp is unchanged, ras_ovf is set.
- ras_ovf and ras_unf are sticky; only reset clears them.
- ISR state:
  - in_isr is set on IRQ accept and cleared on reti when not stalled.
  - While in_isr=1, irq_req is masked (no nesting).
  - ret inside the ISR does not clear in_isr.
- Simultaneous events:
  - irq+ret: irq wins, no pop; net RAS effect is +1.
  - call+ret: ret wins, single pop, no push.
  - reti outside the ISR: behaves as ret.

Optional Feature:
Macro RAS_WRAP_EN.
- Defined: the RAS is circular. A push when full overwrites the oldest entry, sp saturates at STACK_DEPTH, and ras_ovf is still set.
- Not defined: a push when full is dropped, as in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then 3 idle cycles -> pc 000,001,002,003; sel=0 throughout; flags 0.
- At pc=010, call with next_pc=100, then ret at pc=105 -> sel=2 then 3; ret_addr=011; pc returns to 011.
- irq_req at pc=020 -> irq_ack=1, sel=4, pc=004, in_isr=1. A second irq_req is ignored. reti -> pc=020, in_isr=0.
- 5 nested calls from pc=030..034 -> ras_ovf=1. Without RAS_WRAP_EN, 4 rets return 034,033,032,031. With RAS_WRAP_EN, 4 rets return 035,034,033,032.
- ret with empty RAS -> sel=3, pc=000, ras_unf=1 and remains set.
- At pc=3FF, stall for 2 cycles with branch_taken -> pc holds 3FF; after release, sequential step gives pc=000. Reset asserted mid-call -> pc=000, RAS empty.
